// File: rtl/inst_rom_pkg.sv
// Shared definitions for the loadable instruction ROM: loader FSM states,
// default depth and the word returned for any fetch that is not served.
package inst_rom_pkg;

    localparam int          DEPTH_LOG2_DEF = 10;
    localparam logic [31:0] NOP_WORD       = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } rom_state_e;

endpackage

// File: rtl/inst_rom_if.sv
// Fetch and program-load bus between the core/loader (master) and the ROM (slave).
interface inst_rom_if
    import inst_rom_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) ();

    logic                  rom_en;
    logic [31:0]           rom_addr;
    logic [31:0]           rom_data;
    logic                  addr_err;
    logic                  load_start;
    logic                  load_valid;
    logic [7:0]            load_byte;
    logic                  load_last;
    logic                  load_ready;
    logic                  core_hold;
    logic [DEPTH_LOG2:0]   load_words;
    logic                  load_err;

    modport master (
        output rom_en, rom_addr, load_start, load_valid, load_byte, load_last,
        input  rom_data, addr_err, load_ready, core_hold, load_words, load_err
    );

    modport slave (
        input  rom_en, rom_addr, load_start, load_valid, load_byte, load_last,
        output rom_data, addr_err, load_ready, core_hold, load_words, load_err
    );

endinterface

// File: rtl/inst_rom_pack.sv
// Big-endian byte-to-word assembler: collects up to four bytes and strobes a
// write for a full word or for a zero-padded partial word on the last byte.
module inst_rom_pack
    import inst_rom_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic        last,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        wr_en
);

    logic [1:0]  idx_q,  idx_d;
    logic [31:0] asm_q,  asm_d;
    logic [31:0] merged_s;

    // Lanes below the current index are still zero because the register is
    // cleared after every write, which gives the padding for partial words.
    always_comb begin
        merged_s = asm_q;
        case (idx_q)
            2'd0:    merged_s[31:24] = byte_in;
            2'd1:    merged_s[23:16] = byte_in;
            2'd2:    merged_s[15:8]  = byte_in;
            2'd3:    merged_s[7:0]   = byte_in;
            default: merged_s        = asm_q;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        asm_d = asm_q;
        wr_en = accept && ((idx_q == 2'd3) || last);
        word  = merged_s;
        if (clear) begin
            idx_d = 2'd0;
            asm_d = 32'h0000_0000;
        end else if (wr_en) begin
            idx_d = 2'd0;
            asm_d = 32'h0000_0000;
        end else if (accept) begin
            idx_d = idx_q + 2'd1;
            asm_d = merged_s;
        end else begin
            idx_d = idx_q;
            asm_d = asm_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= 2'd0;
            asm_q <= 32'h0000_0000;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
        end
    end

endmodule

// File: rtl/inst_rom.sv
// Byte-loadable instruction ROM: a loader streams a big-endian image in while
// the core is held, then the core fetches words combinationally from it.
module inst_rom
    import inst_rom_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic        clk,
    input  logic        reset,
    inst_rom_if.slave   bus
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};

    rom_state_e              state_q, state_d;
    logic [DEPTH_LOG2-1:0]   ptr_q, ptr_d;
    logic [DEPTH_LOG2:0]     words_q, words_d;
    logic                    err_q, err_d;

    logic                    load_ready_s;
    logic                    accept_s;
    logic                    full_s;
    logic                    wr_s;
    logic [31:0]             word_s;
    logic [DEPTH_LOG2-1:0]   word_idx_s;
    logic                    in_range_s;
    logic                    high_zero_s;
    logic                    fetch_on_s;
    logic [31:0]             rom_data_s;
    logic                    addr_err_s;

    logic [31:0]             mem [0:DEPTH-1];

    assign load_ready_s = (state_q == ST_LOAD) && !bus.load_start;
    assign accept_s     = bus.load_valid && load_ready_s;
    assign full_s       = (words_q == FULL_WORDS);

    inst_rom_pack u_pack (
        .clk     (clk),
        .reset   (reset),
        .clear   (bus.load_start),
        .accept  (accept_s && !full_s),
        .last    (bus.load_last),
        .byte_in (bus.load_byte),
        .word    (word_s),
        .wr_en   (wr_s)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (bus.load_start) state_d = ST_LOAD;
                else                state_d = ST_EMPTY;
            end
            ST_LOAD: begin
                if (bus.load_start)                   state_d = ST_LOAD;
                else if (accept_s && bus.load_last)   state_d = ST_READY;
                else                                  state_d = ST_LOAD;
            end
            ST_READY: begin
                if (bus.load_start) state_d = ST_LOAD;
                else                state_d = ST_READY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Once the array is full, bytes are still accepted (so load_last can end
    // the load) but they are dropped and flagged instead of written.
    always_comb begin
        ptr_d   = ptr_q;
        words_d = words_q;
        err_d   = err_q;
        if (bus.load_start) begin
            ptr_d   = '0;
            words_d = '0;
            err_d   = 1'b0;
        end else if (accept_s && full_s) begin
            err_d   = 1'b1;
        end else if (wr_s) begin
            ptr_d   = ptr_q + DEPTH_LOG2'(1);
            words_d = words_q + (DEPTH_LOG2 + 1)'(1);
        end else begin
            ptr_d   = ptr_q;
            words_d = words_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            words_q <= words_d;
            err_q   <= err_d;
        end
    end

    // The array itself has no reset; fetches are gated by load_words instead.
    always_ff @(posedge clk) begin
        if (wr_s && (state_q == ST_LOAD)) begin
            mem[ptr_q] <= word_s;
        end
    end

    assign word_idx_s  = bus.rom_addr[DEPTH_LOG2+1:2];
    assign in_range_s  = ({1'b0, word_idx_s} < words_q);
    assign high_zero_s = (bus.rom_addr[31:DEPTH_LOG2+2] == '0);
    assign fetch_on_s  = bus.rom_en && (state_q == ST_READY);

    always_comb begin
        rom_data_s = NOP_WORD;
        addr_err_s = 1'b0;
        if (fetch_on_s) begin
            addr_err_s = (bus.rom_addr[1:0] != 2'b00) || !high_zero_s || !in_range_s;
            if (in_range_s && (bus.rom_addr[1:0] == 2'b00)) begin
                rom_data_s = mem[word_idx_s];
            end else begin
                rom_data_s = NOP_WORD;
            end
        end else begin
            rom_data_s = NOP_WORD;
            addr_err_s = 1'b0;
        end
    end

    assign bus.rom_data   = rom_data_s;
    assign bus.addr_err   = addr_err_s;
    assign bus.load_ready = load_ready_s;
    assign bus.core_hold  = (state_q != ST_READY);
    assign bus.load_words = words_q;
    assign bus.load_err   = err_q;

endmodule

// File: doc/inst_rom.md
INST_ROM -- requirements
Module: inst_rom

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, log2 of ROM depth in 32-bit words (DEPTH = 2**DEPTH_LOG2).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 rom_en  in  1  fetch enable from core.
REQ-005 rom_addr  in  32  fetch byte address from core PC.
REQ-006 rom_data  out  32  fetched instruction word.
REQ-007 load_start  in  1  one-cycle pulse; begins a program load at word 0.
REQ-008 load_valid  in  1  load byte valid.
REQ-009 load_byte  in  8  program byte, MIPS big-endian order.
REQ-010 load_last  in  1  qualifies the final byte of the image; sampled with load_valid.
REQ-011 load_ready  out  1  loader accepts a byte this cycle.
REQ-012 core_hold  out  1  core must be held in reset while high.
REQ-013 load_words  out  DEPTH_LOG2+1  words written by the current or last load.
REQ-014 load_err  out  1  sticky overflow flag for the current or last load.
REQ-015 addr_err  out  1  current fetch is outside the loaded image.

Function
REQ-016 FSM states: EMPTY, LOAD, READY.
- EMPTY -> LOAD on load_start.
- LOAD -> READY on an accepted byte with load_last=1.
- READY -> LOAD on load_start.
- load_start in LOAD restarts the load.
REQ-017 core_hold=1 in EMPTY and LOAD; core_hold=0 only in READY.
REQ-018 load_ready = (state==LOAD) && !load_start; a byte is accepted when load_valid && load_ready.
REQ-019 On load_start: word pointer <- 0, byte index <- 0, load_words <- 0, load_err <- 0, assembly register <- 0. Any byte presented in the same cycle is dropped.
REQ-020 Byte packing: byte index 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
REQ-021 On the edge accepting byte index 3: write the full word to mem[ptr], increment ptr, increment load_words, wrap byte index to 0.
REQ-022 On an accepted byte with load_last=1 and byte index < 3: write the partial word to mem[ptr], zero-padding the unwritten low bytes, and increment load_words.
REQ-023 Once load_words == DEPTH, further accepted bytes are discarded, load_err <- 1, and load_words saturates at DEPTH; load_last still completes the load.
REQ-024 rom_data is a combinational read: mem[rom_addr[DEPTH_LOG2+1:2]] when rom_en=1, core_hold=0 and the word index < load_words; otherwise 32'h0 (NOP). No fetch latency: data is valid in the same cycle as the address.
REQ-025 addr_err=1 when rom_en=1, core_hold=0, and either rom_addr[1:0]!=0 or rom_addr[31:DEPTH_LOG2+2]!=0 or word index >= load_words; otherwise 0.
REQ-026 rom_addr[1:0]!=0 also forces rom_data=0.
REQ-027 Memory array writes occur only in LOAD; the core never writes.

Reset
REQ-028 Reset (reset=0, asynchronous) sets state=EMPTY, ptr=0, byte index=0, load_words=0, load_err=0 and assembly register=0.
REQ-029 Resulting outputs during reset: core_hold=1, load_ready=0, rom_data=0, addr_err=0.
REQ-030 The memory array is not reset; its contents are unreachable until a load completes.
REQ-031 Reset asserted mid-load aborts the load; a new load_start is required.

Structure
REQ-032 The shared package holds the FSM state enum, the DEPTH_LOG2 default and the NOP word constant 32'h0.
REQ-033 One sub-module, inst_rom_pack: byte index counter plus assembly register, emitting word and write strobe; the FSM and array live in inst_rom.

Verification
REQ-034 Reset, then load_start, then bytes 3C,01,12,34 with last on 34, then rom_en=1 addr 0 -> rom_data=32'h3C011234, core_hold=0, load_words=1.
REQ-035 Load 6 bytes 11..16 with last on 16 -> word1=32'h15160000, load_words=2; fetch addr 8 -> rom_data=0, addr_err=1.
REQ-036 DEPTH_LOG2=2, stream 20 bytes -> load_words=4, load_err=1, words 0-3 hold the first 16 bytes.
REQ-037 load_start asserted together with load_valid mid-load -> that byte is dropped, load_words=0, core_hold stays 1, and the next byte lands in [31:24] of word 0.
REQ-038 Assert reset mid-load after 2 bytes -> state EMPTY, core_hold=1, rom_data=0; reload succeeds.
REQ-039 In READY, fetch addr 2 -> addr_err=1, rom_data=0; rom_en=0 -> rom_data=0, addr_err=0.
